// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

    localparam int LDR_ADDR_W_DEF = 6;

    typedef enum logic [2:0] {
        LDR_ST_IDLE   = 3'd0,
        LDR_ST_LEN_LO = 3'd1,
        LDR_ST_LEN_HI = 3'd2,
        LDR_ST_DATA   = 3'd3,
        LDR_ST_CSUM   = 3'd4,
        LDR_ST_DONE   = 3'd5,
        LDR_ST_ERROR  = 3'd6
    } ldr_state_e;

    // States in which the loader is consuming frame bytes.
    function automatic logic ldr_is_busy(input ldr_state_e st);
        return (st == LDR_ST_LEN_LO) || (st == LDR_ST_LEN_HI) ||
               (st == LDR_ST_DATA)   || (st == LDR_ST_CSUM);
    endfunction

    // States from which a start request begins a new load.
    function automatic logic ldr_can_start(input ldr_state_e st);
        return (st == LDR_ST_IDLE) || (st == LDR_ST_DONE) || (st == LDR_ST_ERROR);
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: little-endian assembly of data bytes and one-cycle
// instruction memory write pulse per completed word.
module imem_loader_packer #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              last_byte,
    output logic [ADDR_W-1:0] word_idx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   words_loaded
);

    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       pack_q, pack_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   loaded_q, loaded_d;

    // The word count doubles as the index of the next word to write; the
    // loader leaves DATA after word N-1, so it never addresses past DEPTH-1.
    assign last_byte    = (cnt_q == 2'd3);
    assign word_idx     = loaded_q[ADDR_W-1:0];
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = loaded_q;

    // Next-state: place bytes by position, emit a full word on the 4th byte.
    always_comb begin
        cnt_d    = cnt_q;
        pack_d   = pack_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        loaded_d = loaded_q;
        if (clr) begin
            cnt_d    = 2'd0;
            loaded_d = '0;
        end else if (byte_en) begin
            case (cnt_q)
                2'd0: pack_d[7:0]   = byte_in;
                2'd1: pack_d[15:8]  = byte_in;
                2'd2: pack_d[23:16] = byte_in;
                default: begin
                    wdata_d  = {byte_in, pack_q};
                    addr_d   = loaded_q[ADDR_W-1:0];
                    we_d     = 1'b1;
                    // Count moves together with the write pulse.
                    loaded_d = loaded_q + 1'b1;
                end
            endcase
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Packer registers; reset also cancels a pending write pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= 2'd0;
            pack_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            loaded_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            pack_q   <= pack_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            loaded_q <= loaded_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a length/data/checksum byte frame, writes
// the packed words into instruction memory, and releases the core on success.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 2 ** ADDR_W;

    ldr_state_e        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W-1:0] last_idx_q, last_idx_d;
    logic [7:0]        csum_q, csum_d;

    logic              xfer;
    logic              clr;
    logic              byte_en;
    logic              last_byte;
    logic [ADDR_W-1:0] word_idx;
    logic [15:0]       len_full;

    // Status outputs decode straight from the state register, so in_ready
    // has no combinational dependence on in_valid.
    assign busy     = ldr_is_busy(state_q);
    assign in_ready = busy;
    assign done     = (state_q == LDR_ST_DONE);
    assign error    = (state_q == LDR_ST_ERROR);
    assign cpu_rst  = done;

    assign xfer     = in_valid && in_ready;
    assign len_full = {in_data, len_lo_q};

    // Frame parser: length check, checksum accumulation and state sequencing.
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        last_idx_d = last_idx_q;
        csum_d     = csum_q;
        clr        = 1'b0;
        byte_en    = 1'b0;
        case (state_q)
            LDR_ST_IDLE, LDR_ST_DONE, LDR_ST_ERROR: begin
                if (start) begin
                    state_d = LDR_ST_LEN_LO;
                    clr     = 1'b1;
                    csum_d  = 8'h00;
                end
            end
            LDR_ST_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = LDR_ST_LEN_HI;
                end
            end
            LDR_ST_LEN_HI: begin
                if (xfer) begin
                    if ((len_full == 16'd0) || (len_full > 16'(DEPTH))) begin
                        state_d = LDR_ST_ERROR;
                    end else begin
                        // N == DEPTH wraps to 0 here and minus one gives DEPTH-1.
                        last_idx_d = len_full[ADDR_W-1:0] - ADDR_W'(1);
                        state_d    = LDR_ST_DATA;
                    end
                end
            end
            LDR_ST_DATA: begin
                if (xfer) begin
                    byte_en = 1'b1;
                    csum_d  = csum_q ^ in_data;
                    if (last_byte && (word_idx == last_idx_q)) begin
                        state_d = LDR_ST_CSUM;
                    end
                end
            end
            LDR_ST_CSUM: begin
                // The last write pulse fires in this state's first cycle, so
                // DONE can only follow the final memory write.
                if (xfer) begin
                    state_d = (in_data == csum_q) ? LDR_ST_DONE : LDR_ST_ERROR;
                end
            end
            default: state_d = LDR_ST_IDLE;
        endcase
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LDR_ST_IDLE;
            len_lo_q   <= 8'h00;
            last_idx_q <= '0;
            csum_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            last_idx_q <= last_idx_d;
            csum_q     <= csum_d;
        end
    end

    imem_loader_packer #(
        .ADDR_W (ADDR_W)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .byte_en      (byte_en),
        .byte_in      (in_data),
        .last_byte    (last_byte),
        .word_idx     (word_idx),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .words_loaded (words_loaded)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes are queued as
// the frame is driven and compared whenever the loader pulses imem_we.
module tb_imem_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [ADDR_W:0]   wl;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [31:0] wq[$];
    logic [7:0]  frm[$];
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every imem_we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && imem_we) begin
            $display("write addr=%0d data=%08h words_loaded=%0d", imem_addr, imem_wdata, words_loaded);
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("we_addr", 32'(imem_addr), 32'(mon_e.addr));
                check("we_data", imem_wdata, mon_e.data);
                check("we_words_loaded", 32'(words_loaded), 32'(mon_e.wl));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Build a frame from wq; optionally corrupt the checksum.
    task automatic make_frame(input bit bad);
        logic [7:0] cs;
        logic [7:0] b;
        logic [31:0] w;
        int n;
        n  = wq.size();
        cs = 8'h00;
        frm.delete();
        frm.push_back(8'(n));
        frm.push_back(8'(n >> 8));
        for (int k = 0; k < n; k++) begin
            w = wq[k];
            for (int j = 0; j < 4; j++) begin
                b  = w[8*j +: 8];
                cs = cs ^ b;
                frm.push_back(b);
            end
        end
        frm.push_back(bad ? (cs ^ 8'h01) : cs);
    endtask

    // Offer one byte after gap idle cycles; returns on the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap, input bit push);
        int j;
        for (int i = 0; i < frm.size(); i++) begin
            j = i - 2;
            if (push && i >= 2 && j < 4 * wq.size() && (j % 4) == 3) begin
                exp_q.push_back('{addr: ADDR_W'(j / 4), data: wq[j / 4], wl: (ADDR_W+1)'(j / 4 + 1)});
            end
            send_byte(frm[i], gap);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_error", 32'(error), 32'd0);
        check("start_done", 32'(done), 32'd0);
        check("start_cpu_rst", 32'(cpu_rst), 32'd0);
        check("start_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic check_status(input bit e_done, input bit e_err, input int e_wl);
        check("st_done", 32'(done), 32'(e_done));
        check("st_error", 32'(error), 32'(e_err));
        check("st_cpu_rst", 32'(cpu_rst), 32'(e_done));
        check("st_in_ready", 32'(in_ready), 32'd0);
        check("st_busy", 32'(busy), 32'd0);
        check("st_words", 32'(words_loaded), 32'(e_wl));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: two-word image, good checksum
        $display("test1: good two-word load");
        wq = '{32'h0010_0513, 32'h0020_0593};
        make_frame(1'b0);
        do_start();
        send_frame(0, 1'b1);
        check_status(1'b1, 1'b0, 2);

        // 2: same image, bad checksum
        $display("test2: bad checksum");
        make_frame(1'b1);
        do_start();
        send_frame(0, 1'b1);
        check_status(1'b0, 1'b1, 2);

        // 3: zero length and oversize length
        $display("test3: length 0 and length 65");
        do_start();
        frm = '{8'h00, 8'h00};
        send_frame(0, 1'b0);
        check_status(1'b0, 1'b1, 0);
        do_start();
        frm = '{8'h41, 8'h00};
        send_frame(0, 1'b0);
        check_status(1'b0, 1'b1, 0);

        // 5: reset in the middle of a load, right after the 6th byte
        $display("test5: reset mid-load");
        wq = '{32'h0010_0513, 32'h0020_0593};
        make_frame(1'b0);
        do_start();
        for (int i = 0; i < 5; i++) send_byte(frm[i], 0);
        in_data  = frm[5];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_we", 32'(imem_we), 32'd0);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_status(1'b0, 1'b0, 0);

        // 4: in_valid held in IDLE, then a sparse stream
        $display("test4: idle valid hold and sparse stream");
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        do_start();
        send_frame(2, 1'b1);
        check_status(1'b1, 1'b0, 2);

        // 5 (cont.): full stream after the reset gives the same result
        $display("test5: reload after reset");
        do_start();
        send_frame(0, 1'b1);
        check_status(1'b1, 1'b0, 2);

        // 6: full-depth image, then a reload from DONE
        $display("test6: full depth load");
        wq.delete();
        for (int k = 0; k < 64; k++) wq.push_back(32'(k));
        make_frame(1'b0);
        do_start();
        send_frame(0, 1'b1);
        check_status(1'b1, 1'b0, 64);
        $display("test6: reload from DONE");
        wq = '{32'h0010_0513, 32'h0020_0593};
        make_frame(1'b0);
        do_start();
        send_frame(0, 1'b1);
        check_status(1'b1, 1'b0, 2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
